// File: rtl/btn_encoder4.sv
// btn_encoder4 -- player-input front end for the 4-colour game.
//
// Four raw, bouncy push-button lines are synchronised, debounced and encoded
// into a 2-bit colour code. Each accepted press produces exactly one strobe:
// VALID for a single button, ERR for a stable multi-button press. No further
// events are produced until every button has been released (also debounced).
//
// Parameters:
//   DEB_CYCLES  consecutive stable cycles needed to accept a press/release (>= 2)
//   CNT_W       debounce counter width, 2**CNT_W > DEB_CYCLES
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   enable  in   game FSM allows capture of a new press (sampled in IDLE only)
//   btn     in   [3:0] raw buttons, active-high, asynchronous; bit i = colour i
//   cod     out  [1:0] binary index of the last accepted single-button press
//   valid   out  one-cycle strobe, cod updated with a new press
//   err     out  one-cycle strobe, stable multi-button press detected
//   busy    out  high whenever the FSM is not in IDLE
//   led     out  [3:0] echo of the accepted button while it is held
//
// Optional feature: define BTN_LED_ECHO_EN to enable the LED echo. Without it
// led is tied to zero and no echo logic exists.

module btn_encoder4 #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] btn,
  output logic [1:0] cod,
  output logic       valid,
  output logic       err,
  output logic       busy,
  output logic [3:0] led
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [3:0]       sync1_reg, raw_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       cand_reg, cand_next;
  logic [1:0]       cod_reg, cod_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;
  logic             busy_reg;
  logic             cand_one_hot;
  logic [1:0]       cand_idx;
`ifdef BTN_LED_ECHO_EN
  logic [3:0]       led_reg, led_next;
`endif

  // Two-flop synchroniser; everything downstream looks only at raw_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 4'b0000;
      raw_reg   <= 4'b0000;
    end else begin
      sync1_reg <= btn;
      raw_reg   <= sync1_reg;
    end
  end

  // cand is never zero while it matters (captured only when raw != 0).
  assign cand_one_hot = (cand_reg != 4'b0000) &&
                        ((cand_reg & (cand_reg - 4'd1)) == 4'b0000);

  // Binary index of the candidate; only meaningful when it is one-hot.
  always_comb begin
    cand_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cand_reg[i]) cand_idx = 2'(i);
    end
  end

  // Next-state and next-output logic. The counter is cleared on every state
  // change, so it can only ever reach CNT_LAST and never wraps.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    cod_next   = cod_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
`ifdef BTN_LED_ECHO_EN
    led_next   = led_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (enable && (raw_reg != 4'b0000)) begin
          cand_next  = raw_reg;
          cnt_next   = '0;
          state_next = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (raw_reg != cand_reg) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = HELD;
          if (cand_one_hot) begin
            cod_next   = cand_idx;
            valid_next = 1'b1;
`ifdef BTN_LED_ECHO_EN
            led_next   = cand_reg;
`endif
          end else begin
            err_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HELD: begin
        // Anything other than a full release is ignored here.
        if (raw_reg == 4'b0000) begin
          cnt_next   = '0;
          state_next = DEB_REL;
        end
      end
      DEB_REL: begin
        if (raw_reg != 4'b0000) begin
          cnt_next   = '0;
          state_next = HELD;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
`ifdef BTN_LED_ECHO_EN
    if (state_next == IDLE) led_next = 4'b0000;
`endif
  end

  // State register and registered outputs. busy is loaded from the next
  // state so that it always equals (state != IDLE) for the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      cand_reg  <= 4'b0000;
      cod_reg   <= 2'b00;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
      cod_reg   <= cod_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

`ifdef BTN_LED_ECHO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_reg <= 4'b0000;
    else        led_reg <= led_next;
  end
  assign led = led_reg;
`else
  assign led = 4'b0000;
`endif

  assign cod   = cod_reg;
  assign valid = valid_reg;
  assign err   = err_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_btn_encoder4.sv
// Testbench for btn_encoder4 with DEB_CYCLES=4. Expected strobe events
// (kind, code, cycle) are queued when stimulus is driven; a monitor records
// the DUT's strobes and each scenario pops and compares both queues.
module tb_btn_encoder4;
  localparam int DEB = 4;
`ifdef BTN_LED_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [1:0] cod;
  logic       valid, err, busy;
  logic [3:0] led;

  btn_encoder4 #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .btn(btn),
    .cod(cod), .valid(valid), .err(err), .busy(busy), .led(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       v;
    logic       e;
    logic [1:0] cod;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (valid || err) obs_q.push_back('{valid, err, cod, cyc});
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset();
    ev_t e, o;
    rst_n = 1'b0; enable = 1'b0; btn = 4'b0000;
    repeat (3) @(negedge clk);
    checks++; if (cod !== 2'b00)   begin errors++; $display("FAIL reset_cod got %b want 00", cod); end
    checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL reset_led got %b want 0000", led); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_events got %0d want 0", obs_q.size()); end
    obs_q.delete();
    $display("reset: done");
  endtask

  task automatic test_clean_press();
    int t0, t1;
    ev_t e, o;
    enable = 1'b1;
    t0 = cyc; btn = 4'b0100;
    exp_q.push_back('{1'b1, 1'b0, 2'b10, t0 + DEB + 3});
    wait_until(t0 + 2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy_pre got %b want 0", busy); end
    wait_until(t0 + 3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy_on got %b want 1", busy); end
    wait_until(t0 + 20);
    checks++; if (cod !== 2'b10) begin errors++; $display("FAIL clean_cod got %b want 10", cod); end
    checks++; if (led !== (ECHO ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL clean_led got %b want %b", led, ECHO ? 4'b0100 : 4'b0000); end
    t1 = cyc; btn = 4'b0000;
    wait_until(t1 + 6);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy_rel got %b want 1", busy); end
    wait_until(t1 + 7);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy_off got %b want 0", busy); end
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL clean_led_off got %b want 0000", led); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clean_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.v !== e.v || o.e !== e.e || o.cod !== e.cod || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL clean_event got v=%b e=%b cod=%b cyc=%0d want v=%b e=%b cod=%b cyc=%0d", o.v, o.e, o.cod, o.cyc, e.v, e.e, e.cod, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    $display("clean_press: btn=0100 cod=%b", cod);
  endtask

  task automatic test_bounce();
    int c0, t2;
    ev_t e, o;
    c0 = cyc; btn = 4'b0001;
    wait_until(c0 + 2); btn = 4'b0000;
    wait_until(c0 + 3); btn = 4'b0001;
    t2 = cyc;
    exp_q.push_back('{1'b1, 1'b0, 2'b00, t2 + DEB + 3});
    wait_until(t2 + 12);
    btn = 4'b0000;
    wait_until(cyc + 10);
    checks++; if (cod !== 2'b00) begin errors++; $display("FAIL bounce_cod got %b want 00", cod); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bounce_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.v !== e.v || o.e !== e.e || o.cod !== e.cod || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL bounce_event got v=%b e=%b cod=%b cyc=%0d want v=%b e=%b cod=%b cyc=%0d", o.v, o.e, o.cod, o.cyc, e.v, e.e, e.cod, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    $display("bounce: btn=0001 cod=%b", cod);
  endtask

  task automatic test_multi();
    int t;
    ev_t e, o;
    t = cyc; btn = 4'b1010;
    exp_q.push_back('{1'b0, 1'b1, 2'b00, t + DEB + 3});
    wait_until(t + 10);
    checks++; if (cod !== 2'b00) begin errors++; $display("FAIL multi_cod got %b want 00", cod); end
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL multi_led got %b want 0000", led); end
    btn = 4'b0000;
    wait_until(cyc + 10);
    t = cyc; btn = 4'b1000;
    exp_q.push_back('{1'b1, 1'b0, 2'b11, t + DEB + 3});
    wait_until(t + 12);
    checks++; if (cod !== 2'b11) begin errors++; $display("FAIL multi_next_cod got %b want 11", cod); end
    btn = 4'b0000;
    wait_until(cyc + 10);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL multi_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.v !== e.v || o.e !== e.e || o.cod !== e.cod || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL multi_event got v=%b e=%b cod=%b cyc=%0d want v=%b e=%b cod=%b cyc=%0d", o.v, o.e, o.cod, o.cyc, e.v, e.e, e.cod, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    $display("multi: btn=1010 then 1000 cod=%b", cod);
  endtask

  task automatic test_enable_and_hold();
    int t;
    ev_t e, o;
    enable = 1'b0;
    t = cyc; btn = 4'b0010;
    wait_until(t + 10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_busy got %b want 0", busy); end
    enable = 1'b1;
    t = cyc;
    exp_q.push_back('{1'b1, 1'b0, 2'b01, t + DEB + 1});
    wait_until(t + 8);
    checks++; if (led !== (ECHO ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL hold_led got %b want %b", led, ECHO ? 4'b0010 : 4'b0000); end
    btn = 4'b0011;
    wait_until(cyc + 10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %b want 1", busy); end
    checks++; if (led !== (ECHO ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL hold_led2 got %b want %b", led, ECHO ? 4'b0010 : 4'b0000); end
    btn = 4'b0000;
    wait_until(cyc + 10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_off got %b want 0", busy); end
    checks++; if (cod !== 2'b01) begin errors++; $display("FAIL hold_cod got %b want 01", cod); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL hold_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.v !== e.v || o.e !== e.e || o.cod !== e.cod || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL hold_event got v=%b e=%b cod=%b cyc=%0d want v=%b e=%b cod=%b cyc=%0d", o.v, o.e, o.cod, o.cyc, e.v, e.e, e.cod, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    $display("enable_and_hold: btn=0010/0011 cod=%b", cod);
  endtask

  task automatic test_reset_midpress();
    int t, r;
    ev_t e, o;
    enable = 1'b1;
    t = cyc; btn = 4'b0010;
    wait_until(t + 4);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_press_busy got %b want 0", busy); end
    checks++; if (cod !== 2'b00)  begin errors++; $display("FAIL rst_press_cod got %b want 00", cod); end
    checks++; if (valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_press_strobe got %b%b want 00", valid, err); end
    @(negedge clk); rst_n = 1'b1;
    r = cyc;
    exp_q.push_back('{1'b1, 1'b0, 2'b01, r + DEB + 3});
    wait_until(r + 9);
    checks++; if (led !== (ECHO ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL rst_held_led got %b want %b", led, ECHO ? 4'b0010 : 4'b0000); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_held_busy got %b want 0", busy); end
    checks++; if (cod !== 2'b00)   begin errors++; $display("FAIL rst_held_cod got %b want 00", cod); end
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL rst_held_led_off got %b want 0000", led); end
    @(negedge clk); rst_n = 1'b1;
    r = cyc;
    exp_q.push_back('{1'b1, 1'b0, 2'b01, r + DEB + 3});
    wait_until(r + 9);
    btn = 4'b0000;
    wait_until(cyc + 10);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_final_busy got %b want 0", busy); end
    checks++; if (led !== 4'b0000) begin errors++; $display("FAIL rst_final_led got %b want 0000", led); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.v !== e.v || o.e !== e.e || o.cod !== e.cod || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL rst_event got v=%b e=%b cod=%b cyc=%0d want v=%b e=%b cod=%b cyc=%0d", o.v, o.e, o.cod, o.cyc, e.v, e.e, e.cod, e.cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
    $display("reset_midpress: btn=0010 cod=%b", cod);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_enable_and_hold();
    test_reset_midpress();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
